// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage that sits directly in front of instruction_rom. It owns the
// program counter, drives the ROM byte address and captures the returned
// word into an instruction register. Decode reads that register through a
// valid/ready handshake. Execute can redirect the PC for branches and jumps.
// A redirect to a target that is not word aligned parks the unit in a
// sticky trap state, which only reset clears.
//
// Parameters
//   ADDR_W    PC / ROM byte-address width (word index is addr[ADDR_W-1:2])
//   DATA_W    instruction width
//   RESET_PC  PC loaded at reset; must be word aligned
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_ni           asynchronous active-low reset
//   stall_i          freeze the PC and the instruction register
//   redirect_i       load redirect_addr_i into the PC and flush decode's word
//   redirect_addr_i  redirect target byte address
//   rom_addr_o       byte address to the ROM, always the current PC
//   rom_data_i       ROM word for rom_addr_o (combinational, same cycle)
//   instr_o          registered instruction for decode
//   instr_pc_o       PC of instr_o
//   instr_pc4_o      instr_pc_o + 4, wrapping (link value for JAL/JALR)
//   valid_o          instr_o / instr_pc_o hold a word for decode
//   ready_i          decode accepts instr_o this cycle
//   trap_o           misaligned-redirect trap, sticky until reset
//   trap_addr_o      redirect address that caused the trap
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [ADDR_W-1:0] instr_pc4_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              trap_o,
  output logic [ADDR_W-1:0] trap_addr_o
);

  // Byte distance between consecutive instruction words.
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // BOOT marks the single cycle after reset release. It follows exactly
  // the same rules as RUN; it exists so the first cycle is identifiable.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic              valid_reg;
  logic              trap_reg;
  logic [ADDR_W-1:0] trap_addr_reg;

  logic misaligned;
  logic load;

  // Only the two low address bits decide alignment; the upper bits of the
  // target are used as given.
  assign misaligned = (redirect_addr_i[1:0] != 2'b00);

  // The register can take a new word when it is empty or when decode is
  // consuming the current one in this same cycle.
  assign load = !valid_reg || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      instr_reg     <= '0;
      instr_pc_reg  <= '0;
      valid_reg     <= 1'b0;
      trap_reg      <= 1'b0;
      trap_addr_reg <= '0;
    end else begin
      case (state_reg)
        BOOT, RUN: begin
          state_reg <= RUN;
          if (redirect_i && misaligned) begin
            // Bad target: park. The PC keeps its old value so the ROM
            // address never shows the offending target.
            state_reg     <= TRAP;
            trap_reg      <= 1'b1;
            trap_addr_reg <= redirect_addr_i;
            valid_reg     <= 1'b0;
          end else if (redirect_i) begin
            // Flush whatever decode holds; the target word is fetched on
            // the next cycle. A word accepted in this same cycle still
            // counts as consumed by decode.
            pc_reg    <= redirect_addr_i;
            valid_reg <= 1'b0;
          end else if (stall_i) begin
            // Frozen, but a handshake completing during the stall still
            // retires the word so it is not delivered twice.
            if (valid_reg && ready_i) begin
              valid_reg <= 1'b0;
            end
          end else if (load) begin
            instr_reg    <= rom_data_i;
            instr_pc_reg <= pc_reg;
            valid_reg    <= 1'b1;
            pc_reg       <= pc_reg + PC_STEP;  // wraps modulo 2^ADDR_W
          end
          // Otherwise decode is back-pressuring: everything holds.
        end

        TRAP: begin
          // Sticky until reset; all inputs are ignored.
          valid_reg <= 1'b0;
        end

        default: begin
          // Unused encoding: fail safe into the trap state.
          state_reg <= TRAP;
          trap_reg  <= 1'b1;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o  = pc_reg;
  assign instr_o     = instr_reg;
  assign instr_pc_o  = instr_pc_reg;
  assign instr_pc4_o = instr_pc_reg + PC_STEP;  // combinational link value
  assign valid_o     = valid_reg;
  assign trap_o      = trap_reg;
  assign trap_addr_o = trap_addr_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Bench for instruction_fetch_unit. A behavioural ROM answers the address
// combinationally. A directed vector table covers start-up, back-pressure,
// redirects and wrap-around. Hand-written sequences cover trap and
// asynchronous reset. A randomized phase is checked against a small
// reference model of the fetch rules.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] instr_pc4;
  logic              valid;
  logic              ready;
  logic              trap;
  logic [ADDR_W-1:0] trap_addr;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] rom [64];

  instruction_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(8'h00)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_pc4_o    (instr_pc4),
    .valid_o        (valid),
    .ready_i        (ready),
    .trap_o         (trap),
    .trap_addr_o    (trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb rom_data = rom[rom_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs applied for one cycle, outputs expected after
  // the following rising edge.
  typedef struct {
    logic       stall;
    logic       redir;
    logic [7:0] raddr;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_ipc;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs[16];

  // Reference model: the fetch rules written as plain integer arithmetic.
  int m_pc, m_ipc, m_taddr;
  bit m_valid, m_trap;

  function automatic void model_reset();
    m_pc = 0; m_ipc = 0; m_taddr = 0; m_valid = 0; m_trap = 0;
  endfunction

  function automatic void model_step(bit s, bit r, int ra, bit rdy);
    if (m_trap) begin
      m_valid = 0;
    end else if (r && (ra % 4) != 0) begin
      m_trap = 1; m_taddr = ra; m_valid = 0;
    end else if (r) begin
      m_pc = ra; m_valid = 0;
    end else if (s) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      m_ipc = m_pc; m_valid = 1; m_pc = (m_pc + 4) % 256;
    end
  endfunction

  initial begin
    logic [7:0] e_pc4;
    logic [7:0] ra;

    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i * 32'h0101_0101;

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h04};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 8'h08};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 8'h0C};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 8'h0C};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 8'h0C};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 8'h0C};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, 8'h10};
    vecs[7]  = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h0C, 8'h40};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'h44};
    vecs[9]  = '{1'b0, 1'b1, 8'hFC, 1'b1, 1'b0, 8'h40, 8'hFC};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFC, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h04};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h04};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h04};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 8'h08};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 8'h08};

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0; ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", 32'(instr_pc), 32'h0);
    chk("rst_pc4", 32'(instr_pc4), 32'h4);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_taddr", 32'(trap_addr), 32'h0);
    #1 rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redir;
      redirect_addr = vecs[i].raddr; ready = vecs[i].ready;
      @(posedge clk); #1;
      e_pc4 = vecs[i].exp_ipc + 8'd4;
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_ipc", i), 32'(instr_pc), 32'(vecs[i].exp_ipc));
      chk($sformatf("vec%0d_pc4", i), 32'(instr_pc4), 32'(e_pc4));
      chk($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_instr", i), instr, rom[vecs[i].exp_ipc[7:2]]);
      $display("vec %0d: valid=%0b ipc=%h pc4=%h addr=%h instr=%h", i, valid, instr_pc, instr_pc4, rom_addr, instr);
    end

    // Misaligned redirect: sticky trap.
    stall = 1'b0; redirect = 1'b1; redirect_addr = 8'h42; ready = 1'b1;
    @(posedge clk); #1;
    chk("trap_set", 32'(trap), 32'h1);
    chk("trap_addr", 32'(trap_addr), 32'h42);
    chk("trap_valid", 32'(valid), 32'h0);
    chk("trap_pc", 32'(rom_addr), 32'h08);
    $display("trap entry: trap=%0b trap_addr=%h valid=%0b", trap, trap_addr, valid);
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); redirect = 1'($urandom); ready = 1'($urandom);
      redirect_addr = 8'($urandom);
      @(posedge clk); #1;
      chk("trap_hold", 32'(trap), 32'h1);
      chk("trap_hold_valid", 32'(valid), 32'h0);
      chk("trap_hold_pc", 32'(rom_addr), 32'h08);
      chk("trap_hold_addr", 32'(trap_addr), 32'h42);
      $display("trap cycle %0d: trap=%0b valid=%0b addr=%h", i, trap, valid, rom_addr);
    end
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; ready = 1'b1;
    #1;
    chk("trap_clear", 32'(trap), 32'h0);
    chk("trap_clear_addr", 32'(trap_addr), 32'h0);
    #1 rst_n = 1'b1;
    $display("trap cleared by reset: trap=%0b", trap);

    // Asynchronous reset mid-stream.
    repeat (3) @(posedge clk);
    #1;
    chk("stream_valid", 32'(valid), 32'h1);
    chk("stream_ipc", 32'(instr_pc), 32'h08);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_addr", 32'(rom_addr), 32'h0);
    $display("async reset: valid=%0b instr=%h addr=%h", valid, instr, rom_addr);
    #1 rst_n = 1'b1;

    // Randomized phase against the reference model.
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_trap && $urandom_range(0, 14) == 0) begin
        @(posedge clk); #1;
        rst_n = 1'b0; #2 rst_n = 1'b1;
        model_reset();
        $display("rand %0d: reset", cyc);
      end
      stall = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 7) == 0);
      ra = 8'($urandom);
      if ($urandom_range(0, 9) != 0) ra[1:0] = 2'b00;
      else if (ra[1:0] == 2'b00) ra[0] = 1'b1;
      redirect_addr = ra;
      model_step(stall, redirect, int'(ra), ready);
      @(posedge clk); #1;
      chk("rnd_addr", 32'(rom_addr), 32'(m_pc));
      chk("rnd_valid", 32'(valid), 32'(m_valid));
      chk("rnd_trap", 32'(trap), 32'(m_trap));
      if (m_trap) chk("rnd_taddr", 32'(trap_addr), 32'(m_taddr));
      if (m_valid) begin
        chk("rnd_ipc", 32'(instr_pc), 32'(m_ipc));
        chk("rnd_pc4", 32'(instr_pc4), 32'((m_ipc + 4) % 256));
        chk("rnd_instr", instr, rom[m_ipc / 4]);
      end
      $display("rand %0d: s=%0b r=%0b ra=%h rdy=%0b -> valid=%0b ipc=%h addr=%h trap=%0b",
               cyc, stall, redirect, ra, ready, valid, instr_pc, rom_addr, trap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
